// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the multiply/divide unit: md_op encodings,
// FSM state encodings and small op-classification helpers.
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for the four ops that occupy the unit for several cycles
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  // True for every op that touches the unit (and so must wait while busy)
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  // True for mult/multu, which use the shorter latency
  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// E-stage bus between the pipeline (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       md_op;
  logic             md_valid;
  logic             cancel;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             md_stall;
  logic [WIDTH-1:0] md_rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output md_op, md_valid, cancel, rs_val, rt_val,
    input  busy, md_stall, md_rdata, hi, lo
  );

  modport slave (
    input  md_op, md_valid, cancel, rs_val, rt_val,
    output busy, md_stall, md_rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_core.sv
// Purely combinational arithmetic for the multiply/divide unit. Works on the
// latched op and operands; the parent decides when the result is committed.
module muldiv_core
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   quot_u;
  logic        [WIDTH-1:0]   rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  // Products, quotients and remainders; the divider is guarded so a zero
  // divisor or the signed overflow case never reaches the / and % operators
  always_comb begin
    prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero = (b == '0);
    div_ovf  = (a == MOST_NEG) && (b == '1);
    quot_s   = '0;
    rem_s    = '0;
    quot_u   = '0;
    rem_u    = '0;
    if (!div_zero && !div_ovf) begin
      quot_s = $signed(a) / $signed(b);
      rem_s  = $signed(a) % $signed(b);
    end
    if (!div_zero) begin
      quot_u = a / b;
      rem_u  = a % b;
    end
  end

  // Select HI/LO for the latched op; divide by zero yields LO=all ones, HI=dividend
  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT: begin
        hi_res = prod_s[2*WIDTH-1:WIDTH];
        lo_res = prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        hi_res = prod_u[2*WIDTH-1:WIDTH];
        lo_res = prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = '1;
        end else if (div_ovf) begin
          hi_res = '0;
          lo_res = MOST_NEG;
        end else begin
          hi_res = rem_s;
          lo_res = quot_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          hi_res = a;
          lo_res = '1;
        end else begin
          hi_res = rem_u;
          lo_res = quot_u;
        end
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Holds the IDLE/BUSY
// FSM, the latency counter, the operand latches and HI/LO; arithmetic lives
// in muldiv_core.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (core_hi),
    .lo_res (core_lo)
  );

  // Next-state logic: start or move-to-HI/LO from IDLE, count down in BUSY,
  // commit the result on the last count unless cancel arrives at the same time
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    accept  = bus.md_valid && !busy_q && !bus.cancel;
    case (state_q)
      MD_IDLE: begin
        if (accept && is_arith_op(bus.md_op)) begin
          state_d = MD_BUSY;
          busy_d  = 1'b1;
          op_d    = md_op_e'(bus.md_op);
          a_d     = bus.rs_val;
          b_d     = bus.rt_val;
          cnt_d   = is_mult_op(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (accept && (bus.md_op == MD_MTHI)) begin
          hi_d = bus.rs_val;
        end else if (accept && (bus.md_op == MD_MTLO)) begin
          lo_d = bus.rs_val;
        end
      end
      MD_BUSY: begin
        if (bus.cancel) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = core_hi;
          lo_d    = core_lo;
          state_d = MD_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latches and HI/LO; reset clears everything and aborts any op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  // Read port shows committed HI/LO only; the in-flight result is never bypassed
  always_comb begin
    bus.md_rdata = '0;
    if (bus.md_op == MD_MFHI) begin
      bus.md_rdata = hi_q;
    end else if (bus.md_op == MD_MFLO) begin
      bus.md_rdata = lo_q;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.md_stall = bus.md_valid && is_md_op(bus.md_op) && busy_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed vector table, hand-written
// multi-cycle sequences, then randomized ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  vec_t        vecs[11];

  // Reference: HI/LO after an op, from plain 64-bit arithmetic
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
    longint          sq;
    longint          sr;
    longint unsigned up;
    case (op)
      4'd1: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        return sq;
      end
      4'd2: begin
        up = 64'(a) * 64'(b);
        return up;
      end
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      4'd7:    return {a, cur_lo};
      4'd8:    return {cur_hi, a};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic canc);
    bus.md_op    = op;
    bus.md_valid = valid;
    bus.rs_val   = a;
    bus.rt_val   = b;
    bus.cancel   = canc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op for a single edge, then count busy cycles (bounded)
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    applyStimulus(op, 1'b1, a, b, 1'b0);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [63:0] r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_n;

    vecs[0]  = '{MD_MULT,  32'd3,          32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF,   32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{MD_DIV,   32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
    vecs[3]  = '{MD_DIVU,  32'd7,          32'd0,        32'h00000007, 32'hFFFFFFFF, DC};
    vecs[4]  = '{MD_DIV,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vecs[5]  = '{MD_DIV,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vecs[6]  = '{MD_DIV,   32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, DC};
    vecs[7]  = '{MD_MTHI,  32'h12345678,   32'd0,        32'h12345678, 32'hFFFFFFFF, 0};
    vecs[8]  = '{MD_MTLO,  32'hCAFEF00D,   32'd0,        32'h12345678, 32'hCAFEF00D, 0};
    vecs[9]  = '{MD_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[10] = '{MD_MULT,  32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, MC};

    // Reset state
    applyStimulus(MD_MFHI, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    checkOutput("reset_rdata", bus.md_rdata, 32'd0);
    reset = 1'b1;

    // Vector table; the first start lands on the first edge after release
    for (int i = 0; i < 11; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, n);
      checkOutput($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
      checkOutput($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
      checkOutput($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
      applyStimulus(MD_MFHI, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_mfhi", i), bus.md_rdata, vecs[i].exp_hi);
      applyStimulus(MD_MFLO, 1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      checkOutput($sformatf("vec%0d_mflo", i), bus.md_rdata, vecs[i].exp_lo);
      applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    end

    // mflo stalls behind a mult and never sees the in-flight product
    runOp(MD_MTLO, 32'hDEADBEEF, 32'd0, n);
    applyStimulus(MD_MULT, 1'b1, 32'd5, 32'd7, 1'b0);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(MD_MFLO, 1'b1, 32'd0, 32'd0, 1'b0);
    #1;
    n = 0;
    while (bus.busy && n < 50) begin
      checkOutput("mflo_stall", 32'(bus.md_stall), 32'd1);
      checkOutput("mflo_no_bypass", bus.md_rdata, 32'hDEADBEEF);
      n++;
      tick();
    end
    checkOutput("mflo_wait_cycles", 32'(n), 32'(MC - 1));
    checkOutput("mflo_stall_release", 32'(bus.md_stall), 32'd0);
    checkOutput("mflo_new_lo", bus.md_rdata, 32'd35);
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);

    // Start and mthi while busy are stalled and ignored
    applyStimulus(MD_MULTU, 1'b1, 32'd6, 32'd9, 1'b0);
    tick();
    applyStimulus(MD_DIV, 1'b1, 32'd100, 32'd3, 1'b0);
    #1;
    checkOutput("busy_start_stall", 32'(bus.md_stall), 32'd1);
    tick();
    applyStimulus(MD_MTHI, 1'b1, 32'hBAD0BAD0, 32'd0, 1'b0);
    #1;
    checkOutput("busy_mthi_stall", 32'(bus.md_stall), 32'd1);
    tick();
    applyStimulus(4'd12, 1'b1, 32'd1, 32'd1, 1'b0);
    #1;
    checkOutput("busy_op12_no_stall", 32'(bus.md_stall), 32'd0);
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      tick();
    end
    checkOutput("busy_ignore_cycles", 32'(n), 32'(MC - 2));
    checkOutput("busy_ignore_hi", bus.hi, 32'd0);
    checkOutput("busy_ignore_lo", bus.lo, 32'd54);

    // Cancel on the final count wins over the write
    runOp(MD_MTHI, 32'h11112222, 32'd0, n);
    runOp(MD_MTLO, 32'h33334444, 32'd0, n);
    applyStimulus(MD_DIV, 1'b1, 32'd100, 32'd7, 1'b0);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (DC - 1) tick();
    checkOutput("cancel_last_still_busy", 32'(bus.busy), 32'd1);
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("cancel_last_busy", 32'(bus.busy), 32'd0);
    tick();
    checkOutput("cancel_last_hi", bus.hi, 32'h11112222);
    checkOutput("cancel_last_lo", bus.lo, 32'h33334444);

    // Cancel mid-operation
    applyStimulus(MD_DIVU, 1'b1, 32'd50, 32'd4, 1'b0);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (DC) tick();
    checkOutput("cancel_mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("cancel_mid_lo", bus.lo, 32'h33334444);

    // Cancel alongside a start or a move-to suppresses it
    applyStimulus(MD_MULT, 1'b1, 32'd3, 32'd3, 1'b1);
    tick();
    checkOutput("cancel_start_busy", 32'(bus.busy), 32'd0);
    applyStimulus(MD_MTHI, 1'b1, 32'hFFFF0000, 32'd0, 1'b1);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("cancel_mthi_hi", bus.hi, 32'h11112222);

    // Unused op codes change nothing
    foreach (vecs[i]) begin
      if (i < 8) begin
        op = (i == 0) ? 4'd0 : 4'(8 + i);
        applyStimulus(op, 1'b1, $urandom, $urandom, 1'b0);
        tick();
        checkOutput($sformatf("noop%0d_busy", op), 32'(bus.busy), 32'd0);
        checkOutput($sformatf("noop%0d_hi", op), bus.hi, 32'h11112222);
        checkOutput($sformatf("noop%0d_lo", op), bus.lo, 32'h33334444);
      end
    end
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a divide
    applyStimulus(MD_DIV, 1'b1, 32'd1000, 32'd3, 1'b0);
    tick();
    applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checkOutput("areset_busy", 32'(bus.busy), 32'd0);
    checkOutput("areset_hi", bus.hi, 32'd0);
    checkOutput("areset_lo", bus.lo, 32'd0);
    tick();
    reset = 1'b1;
    repeat (DC) tick();
    checkOutput("areset_no_late_lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Randomized ops against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (op == MD_MFHI || op == MD_MFLO) begin
        applyStimulus(op, 1'b1, a, b, 1'b0);
        #1;
        checkOutput($sformatf("rnd%0d_rdata", k), bus.md_rdata, (op == MD_MFHI) ? m_hi : m_lo);
        tick();
        applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0, 1'b0);
      end else begin
        r     = refModel(op, a, b, m_hi, m_lo);
        m_hi  = r[63:32];
        m_lo  = r[31:0];
        exp_n = (op == MD_MULT || op == MD_MULTU) ? MC :
                (op == MD_DIV || op == MD_DIVU) ? DC : 0;
        runOp(op, a, b, n);
        checkOutput($sformatf("rnd%0d_op%0d_cycles", k, op), 32'(n), 32'(exp_n));
        checkOutput($sformatf("rnd%0d_op%0d_hi", k, op), bus.hi, m_hi);
        checkOutput($sformatf("rnd%0d_op%0d_lo", k, op), bus.lo, m_lo);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
